// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared funct3 encodings, FSM state type and access-decode
//             helpers for the data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Latency counter width; covers LATENCY-1 for LATENCY in 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Loads accept the five RV32I load encodings
    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Stores accept SB/SH/SW only
    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_load_ext
//  Purpose  : Combinational load-lane selection and sign/zero extension.
//             Halfword ignores off[0]; word ignores off[1:0].
//  Revision : 1.0  initial release
// ============================================================================
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane, then extend according to funct3
    always_comb begin
        sel_byte = 8'h00;
        sel_half = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
        ext_data = 32'h0;
        case (byte_off)
            2'b00:   sel_byte = raw_word[7:0];
            2'b01:   sel_byte = raw_word[15:8];
            2'b10:   sel_byte = raw_word[23:16];
            default: sel_byte = raw_word[31:24];
        endcase
        case (funct3)
            F3_B:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   ext_data = {24'h0, sel_byte};
            F3_H:    ext_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   ext_data = {16'h0, sel_half};
            F3_W:    ext_data = raw_word;
            default: ext_data = 32'h0;
        endcase
    end

endmodule : dmem_load_ext
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Single-outstanding data-memory responder with byte/half/word
//             lanes and fixed access latency.
//  Options  : DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses fault
//             (rsp_err=1, no write, zero load data) instead of being
//             forced aligned.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        raw_word;
    logic [31:0]        load_val;
    logic               f3_bad;
    logic               fault;
    logic               fault_err;
    logic               do_access;
    logic [3:0]         lane_en;
    logic [31:0]        lane_data;
    logic               unused_addr_hi;

    // Address bits above the memory size only wrap, they never select
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign word_idx  = addr_q[ADDR_W+1:2];
    assign raw_word  = mem[word_idx];
    assign f3_bad    = we_q ? !store_f3_ok(f3_q) : !load_f3_ok(f3_q);
    assign do_access = (state_q == BUSY) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault     = f3_bad || is_misaligned(f3_q, addr_q[1:0]);
    assign fault_err = fault;
`else
    assign fault     = f3_bad;
    assign fault_err = 1'b0;
`endif

    dmem_load_ext u_load_ext (
        .raw_word (raw_word),
        .byte_off (addr_q[1:0]),
        .funct3   (f3_q),
        .ext_data (load_val)
    );

    // Store lane enables and lane-replicated write data
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = 32'h0;
        case (f3_q[1:0])
            2'b00: begin
                lane_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                lane_en   = 4'b1111;
                lane_data = wdata_q;
            end
            default: lane_en = 4'b0000;
        endcase
        if (fault || !we_q) begin
            lane_en = 4'b0000;
        end
    end

    // Storage is not reset; a store lands exactly once on the BUSY->RESP edge
    always_ff @(posedge clk) begin
        if (do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Next-state, request capture and response formation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rdata_d = (we_q || fault) ? 32'h0 : load_val;
                    err_d   = fault_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder using a byte-addressed
//             memory model and directed load/store vectors.
//  Options  : DMEM_MISALIGN_TRAP_EN - selects the trapping expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int MEMB    = 4 << ADDR_W;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Byte-addressed model of the memory contents
    logic [7:0]  mbytes [MEMB];

    // Expectations for the transaction in flight
    bit          txn_active = 1'b0;
    int          rsp_edge   = 0;
    int          done_at    = 0;
    logic [31:0] exp_rdata  = 32'h0;
    logic        exp_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: loads/stores as byte sequences on a flat byte array
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int a;
        int sz;
        bit bad;
        bit mis;
        logic [31:0] v;
        a   = int'(addr[ADDR_W+1:0]);
        sz  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = (a % sz) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        er  = bad || mis;
`else
        er  = 1'b0;
        a   = a - (a % sz);
        mis = 1'b0;
`endif
        rd = 32'h0;
        if (!bad && !mis) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mbytes[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mbytes[a + i];
                if (!f3[2] && sz < 4 && v[8*sz-1]) begin
                    for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endtask

    // Per-cycle comparison of handshake and response against the model
    always @(posedge clk) begin
        #2;
        if (txn_active && cyc < done_at) begin
            check("req_ready_busy", {31'h0, req_ready}, 32'h0);
            if (cyc < rsp_edge) begin
                check("rsp_valid_early", {31'h0, rsp_valid}, 32'h0);
            end else begin
                check("rsp_valid_due", {31'h0, rsp_valid}, 32'h1);
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
            end
        end else begin
            check("req_ready_idle", {31'h0, req_ready}, 32'h1);
            check("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
        end
    end

    // One complete transaction; optional literal expectations pin the model
    task automatic access(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input bit use_lit, input logic [31:0] lit, input logic lit_err);
        logic [31:0] rd;
        logic        er;
        int          k;
        model_access(we, f3, addr, wd, rd, er);
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        exp_rdata  = rd;
        exp_err    = er;
        rsp_edge   = cyc + 1 + LATENCY;
        done_at    = 32'h7FFFFFFF;
        txn_active = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        k = 0;
        while (!rsp_valid && k < LATENCY + 4) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: rsp_valid=%b, expected 1 within %0d cycles", name, rsp_valid, LATENCY + 4);
        end
        if (use_lit) begin
            check({name, "_lit"}, rsp_rdata, lit);
            check({name, "_lit_err"}, {31'h0, rsp_err}, {31'h0, lit_err});
        end
        repeat (hold) @(negedge clk);
        rsp_ready  = 1'b1;
        done_at    = cyc + 1;
        @(negedge clk);
        rsp_ready  = 1'b0;
        txn_active = 1'b0;
    endtask

    logic [31:0] misal_word;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < MEMB; i++) mbytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'h0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);

        // Word store/load
        access("sw_dead",  1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0);
        access("lw_dead",  1'b0, 3'b010, 32'h40, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte lanes and extension
        access("sw_zero",  1'b1, 3'b010, 32'h40, 32'h0,        0, 1'b0, 32'h0, 1'b0);
        access("sb_80",    1'b1, 3'b000, 32'h41, 32'hFFFFFF80, 0, 1'b0, 32'h0, 1'b0);
        access("lb_41",    1'b0, 3'b000, 32'h41, 32'h0,        0, 1'b1, 32'hFFFFFF80, 1'b0);
        access("lbu_41",   1'b0, 3'b100, 32'h41, 32'h0,        0, 1'b1, 32'h00000080, 1'b0);
        access("lw_after_sb", 1'b0, 3'b010, 32'h40, 32'h0,     0, 1'b1, 32'h00008000, 1'b0);

        // Halfword lanes
        access("sh_1234",  1'b1, 3'b001, 32'h42, 32'hABCD1234, 0, 1'b0, 32'h0, 1'b0);
        access("lhu_42",   1'b0, 3'b101, 32'h42, 32'h0,        0, 1'b1, 32'h00001234, 1'b0);
        access("lw_after_sh", 1'b0, 3'b010, 32'h40, 32'h0,     0, 1'b1, 32'h12348000, 1'b0);
        access("sh_8765",  1'b1, 3'b001, 32'h40, 32'h00008765, 0, 1'b0, 32'h0, 1'b0);
        access("lh_40",    1'b0, 3'b001, 32'h40, 32'h0,        0, 1'b1, 32'hFFFF8765, 1'b0);

        // Back-pressure: response held for 5 cycles
        access("lw_hold",  1'b0, 3'b010, 32'h40, 32'h0,        5, 1'b1, 32'h12348765, 1'b0);

        // Misaligned word store
`ifdef DMEM_MISALIGN_TRAP_EN
        misal_word = 32'h12348765;
        access("sw_misal", 1'b1, 3'b010, 32'h43, 32'h55667788, 0, 1'b1, 32'h0, 1'b1);
`else
        misal_word = 32'h55667788;
        access("sw_misal", 1'b1, 3'b010, 32'h43, 32'h55667788, 0, 1'b1, 32'h0, 1'b0);
`endif
        access("lw_after_misal", 1'b0, 3'b010, 32'h40, 32'h0,  0, 1'b1, misal_word, 1'b0);

        // Undefined funct3: load returns 0, store writes nothing
`ifdef DMEM_MISALIGN_TRAP_EN
        access("ld_f3_bad", 1'b0, 3'b011, 32'h40, 32'h0,       0, 1'b1, 32'h0, 1'b1);
`else
        access("ld_f3_bad", 1'b0, 3'b011, 32'h40, 32'h0,       0, 1'b1, 32'h0, 1'b0);
`endif
        access("st_f3_bad", 1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 0, 1'b0, 32'h0, 1'b0);
        access("lw_after_bad", 1'b0, 3'b010, 32'h40, 32'h0,    0, 1'b1, misal_word, 1'b0);

        // Address wrap beyond the memory size
        access("sw_wrap",  1'b1, 3'b010, 32'h1040, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b0);
        access("lw_wrap",  1'b0, 3'b010, 32'h40,   32'h0,      0, 1'b1, 32'hA5A5A5A5, 1'b0);
        access("lb_43",    1'b0, 3'b000, 32'h43,   32'h0,      0, 1'b1, 32'hFFFFFFA5, 1'b0);

        // Reset during BUSY abandons a store
        access("sw_prior", 1'b1, 3'b010, 32'h80, 32'h11112222, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h80;
        req_wdata  = 32'hCAFEF00D;
        req_valid  = 1'b1;
        exp_rdata  = 32'h0;
        exp_err    = 1'b0;
        rsp_edge   = cyc + 1 + LATENCY;
        done_at    = 32'h7FFFFFFF;
        txn_active = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        rst        = 1'b1;
        txn_active = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        check("rst_abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        access("lw_after_rst", 1'b0, 3'b010, 32'h80, 32'h0,    0, 1'b1, 32'h11112222, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
